counter_arbiter: RTL
====================

Name: counter_arbiter

Overview:
- Shares one up/down counter instance, with ports clk, rst, control[1:0] and count[W-1:0], between N requesters. INC is 01, DEC is 10, and any other value holds.
- Requesters post INC/DEC operations with a valid/ready handshake. A round-robin arbiter picks one request at a time.
- The block bounds-checks the picked request against the counter's current value, then drives the counter's control input for exactly one cycle.
- It sits between client logic (credit/occupancy trackers) and the counter datapath.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, counter width; must match the counter instance.
- LIMIT, 2**W-1, highest legal count value; an INC at LIMIT is rejected.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, is released synchronously by the integrator.
- req_valid  input  N  per-requester request valid.
- req_op  input  2*N  per-requester op; slice [2i+1:2i] belongs to requester i; 01=INC, 10=DEC.
- req_ready  output  N  one-hot accept strobe; transfer on req_valid[i]&req_ready[i].
- req_err  output  1  qualifies the accept strobe: 1 = rejected (bound violation or illegal op), counter untouched.
- count_in  input  W  current count from the counter instance.
- ctrl  output  2  drives counter control; registered.
- grant_id  output  clog2(N)  index of the last accepted requester; registered.
- busy  output  1  high in ISSUE state.

Behaviour:
- Reset (rst=0) values: state=IDLE, ctrl=00, grant_id=0, busy=0, round-robin pointer=N-1 (so requester 0 wins first). req_ready=0 and req_err=0 follow from state.
- FSM has two states, IDLE and ISSUE.
- IDLE, no valid requests: ctrl=00, state stays IDLE.
- IDLE, at least one valid request:
  - Grant goes to the first valid requester found by searching from pointer+1 upward with wrap-around.
  - req_ready[g]=1 is asserted combinationally in that same cycle, and the pointer is updated to g.
  - grant_id<=g.
- Legality check, on the granted request in the same IDLE cycle:
  - INC is legal iff count_in != LIMIT.
  - DEC is legal iff count_in != 0.
  - Ops 00 and 11 are always illegal.
- Legal grant: req_err=0; ctrl<=op at the next edge; state<=ISSUE.
- Illegal grant: req_err=1; ctrl stays 00; state stays IDLE. The next arbitration happens in the following cycle.
- ISSUE:
  - ctrl holds the op for exactly this one cycle, and the counter updates at the end of this cycle.
  - req_ready=0 for all requesters; busy=1.
  - Next edge: ctrl<=00, state<=IDLE.
  - count_in is valid again in IDLE, so no op is ever checked against a stale count.
- Throughput: one legal op per 2 cycles; one rejected op per cycle.
- Latency: from accept to count_in updated is 2 edges.
- A requester that holds req_valid after acceptance posts a new request. It is re-arbitrated normally, behind the other requesters in round-robin order.
- Requests whose req_valid drops before grant are dropped silently; no state is kept for them.
- Reset mid-ISSUE: ctrl forces to 00 immediately.
  - The counter shares rst, so it also clears; no partial op survives.
- count_in only changes due to this block's ctrl. The counter's wrap-around is never exercised, because bounds are enforced here.

Optional Feature:
- Macro: COUNTER_ARB_PRIO_EN.
- Defined: requester 0 has fixed highest priority. If req_valid[0]=1 in IDLE, it wins regardless of the pointer, and the pointer is not updated by its grant. Other requesters use round-robin among themselves.
- Undefined: pure round-robin over all N requesters, as described above.

Test Plan:
- Reset then single INC: rst low then high, req_valid=0001, op0=01, count_in from counter=0 → req_ready=0001 with req_err=0 in cycle 0; ctrl=01 in cycle 1, busy=1; count=1 in cycle 2; ctrl=00.
- Fairness: all 4 requesters valid INC continuously from count 0 → grant order 0,1,2,3,0. One grant every 2 cycles, count reaches 5 after 10 cycles.
- Upper bound: W=8, count=255, requester 2 INC → req_ready=0100, req_err=1; ctrl stays 00; count stays 255; next grant the following cycle.
- Lower bound and illegal op: count=0, requester 1 DEC → req_err=1. Then op 11 from requester 3 → req_err=1, count unchanged at 0.
- Reset during ISSUE: assert rst while ctrl=10 → ctrl=00, busy=0 immediately; count=0; the first grant after release goes to requester 0.
- With COUNTER_ARB_PRIO_EN: requesters 0 and 1 both valid continuously → requester 0 granted every IDLE cycle, requester 1 starved. Without the macro → grants alternate 0,1,0,1.

Source files
------------

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
//
// Lets N requesters share one up/down counter. A round-robin arbiter picks one
// valid request per IDLE cycle and checks it against the counter's current
// value. A legal op is driven onto the counter control for exactly one cycle
// (ISSUE state). An illegal op is acknowledged with req_err and leaves the
// counter untouched.
//
// Optional build macro: COUNTER_ARB_PRIO_EN
//   defined   : requester 0 has fixed top priority. Its grants do not move the
//               round-robin pointer.
//   undefined : pure round-robin over all N requesters.
//
// Parameters:
//   N     number of requesters (2..16)
//   W     counter width; must match the counter instance
//   LIMIT highest legal count; an INC at LIMIT is rejected
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   [N]     per-requester request valid
//   req_op     in   [2N]    per-requester op, slice [2i+1:2i]; 01=INC, 10=DEC
//   req_ready  out  [N]     one-hot accept strobe (combinational, IDLE only)
//   req_err    out  1       accept was a rejection (bound hit / illegal op)
//   count_in   in   [W]     current count from the counter instance
//   ctrl       out  [2]     counter control, registered
//   grant_id   out  [IDW]   index of the last accepted requester, registered
//   busy       out  1       high while in ISSUE
// -----------------------------------------------------------------------------
module counter_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  parameter logic [W-1:0] LIMIT = {W{1'b1}},
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [2*N-1:0] req_op,
  output logic [N-1:0]   req_ready,
  output logic           req_err,
  input  logic [W-1:0]   count_in,
  output logic [1:0]     ctrl,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [IDW-1:0] ptr_r, ptr_nxt_s;
  logic [1:0]     ctrl_r, ctrl_nxt_s;
  logic [IDW-1:0] grant_id_r, grant_id_nxt_s;
  logic           busy_r, busy_nxt_s;

  logic           found_s;
  logic           prio_hit_s;
  logic [IDW-1:0] grant_s;
  logic [1:0]     op_s;
  logic           legal_s;

  // INC needs headroom below LIMIT, DEC needs a non-zero count, and any other
  // encoding is rejected outright.
  function automatic logic op_legal(input logic [1:0] op, input logic [W-1:0] cnt);
    case (op)
      2'b01:   return (cnt != LIMIT);
      2'b10:   return (cnt != {W{1'b0}});
      default: return 1'b0;
    endcase
  endfunction

  // Winner selection. The first pass looks strictly above the pointer and the
  // second pass wraps to the indices at or below it. This gives a search order
  // of pointer+1 upward with wrap-around.
  always_comb begin
    found_s    = 1'b0;
    prio_hit_s = 1'b0;
    grant_s    = {IDW{1'b0}};
`ifdef COUNTER_ARB_PRIO_EN
    if (req_valid[0]) begin
      found_s    = 1'b1;
      prio_hit_s = 1'b1;
      grant_s    = {IDW{1'b0}};
    end else begin
      found_s    = 1'b0;
    end
`endif
    for (int j = 0; j < int'(N); j++) begin
      if (!found_s && req_valid[j] && (j > int'(ptr_r))) begin
        found_s = 1'b1;
        grant_s = IDW'(j);
      end else begin
        found_s = found_s;
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!found_s && req_valid[j] && (j <= int'(ptr_r))) begin
        found_s = 1'b1;
        grant_s = IDW'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign op_s    = req_op[{grant_s, 1'b0} +: 2];
  assign legal_s = op_legal(op_s, count_in);

  // Next-state and handshake logic. The check in IDLE always sees a settled
  // count_in, because the counter updates at the end of ISSUE.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    ctrl_nxt_s     = 2'b00;
    grant_id_nxt_s = grant_id_r;
    busy_nxt_s     = 1'b0;
    req_ready      = {N{1'b0}};
    req_err        = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          req_ready      = {{(N-1){1'b0}}, 1'b1} << grant_s;
          grant_id_nxt_s = grant_s;
          // A fixed-priority win leaves the rotation of the others unchanged.
          if (prio_hit_s) begin
            ptr_nxt_s = ptr_r;
          end else begin
            ptr_nxt_s = grant_s;
          end
          if (legal_s) begin
            ctrl_nxt_s  = op_s;
            busy_nxt_s  = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            req_err     = 1'b1;
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears ctrl at once, so a mid-ISSUE
  // reset cannot leave a partial op on the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      ptr_r      <= IDW'(N - 1);
      ctrl_r     <= 2'b00;
      grant_id_r <= {IDW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      ctrl_r     <= ctrl_nxt_s;
      grant_id_r <= grant_id_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign ctrl     = ctrl_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;

endmodule
